// File: rtl/decompress_pkg.sv
`default_nettype none
// ============================================================================
// Module      : decompress_pkg
// Description : Shared constants, types and helpers for the decompression
//               dispatch group (512-to-64).
// Revision    : 1.0 - initial release
// ============================================================================
package decompress_pkg;

  // Engine-index width for a given lane count (at least one bit)
  function automatic int eng_w_of(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  localparam int DECOMPRESS_ENGINES_NO = 24;
  localparam int DECOMPRESS_WORD_SIZE  = 64;
  localparam int VALUE_SIZE_BYTES_NO   = 2;
  localparam int ENG_W                 = eng_w_of(DECOMPRESS_ENGINES_NO);

  // Wide enough for any credit limit from 1 to 15
  localparam int CREDIT_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SEARCH = 2'd1,
    ST_GRANT  = 2'd2
  } sched_state_t;

endpackage
`default_nettype wire

// File: rtl/decompress_order_fifo.sv
`default_nettype none
// ============================================================================
// Module      : decompress_order_fifo
// Description : Show-ahead FIFO that records the grant order of engine lanes.
//               Head data is valid whenever the FIFO is not empty.
// Revision    : 1.0 - initial release
// ============================================================================
module decompress_order_fifo #(
  parameter int WIDTH     = 5,
  parameter int ADDR_BITS = 6
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_push,
  input  logic [WIDTH-1:0]     i_data,
  input  logic                 i_pop,
  output logic [WIDTH-1:0]     o_data,
  output logic                 o_full,
  output logic                 o_empty,
  output logic [ADDR_BITS:0]   o_count
);

  localparam int DEPTH = 1 << ADDR_BITS;

  logic [WIDTH-1:0]     r_mem [DEPTH];
  logic [ADDR_BITS-1:0] r_wr_ptr;
  logic [ADDR_BITS-1:0] r_rd_ptr;
  logic [ADDR_BITS:0]   r_count;
  logic                 w_push;
  logic                 w_pop;

  assign o_full  = (r_count == (ADDR_BITS+1)'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_count = r_count;
  assign o_data  = r_mem[r_rd_ptr];

  // Overflow/underflow protection: requests are ignored when they cannot complete
  assign w_push = i_push && !o_full;
  assign w_pop  = i_pop && !o_empty;

  // Storage array; contents need no reset because occupancy gates visibility
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= i_data;
    end
  end

  // Pointer and occupancy bookkeeping
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/decompress_dispatch_sched.sv
`default_nettype none
// ============================================================================
// Module      : decompress_dispatch_sched
// Description : Credit-based round-robin scheduler choosing the engine lane
//               for each incoming value, recording grant order so the output
//               collector can drain lanes in arrival order.
// Revision    : 1.0 - initial release
// ============================================================================
module decompress_dispatch_sched
  import decompress_pkg::sched_state_t;
  import decompress_pkg::ST_IDLE;
  import decompress_pkg::ST_SEARCH;
  import decompress_pkg::ST_GRANT;
  import decompress_pkg::CREDIT_W;
#(
  parameter  int DECOMPRESS_ENGINES_NO = decompress_pkg::DECOMPRESS_ENGINES_NO,
  parameter  int VALUE_SIZE_BYTES_NO   = decompress_pkg::VALUE_SIZE_BYTES_NO,
  parameter  int MAX_OUTSTANDING       = 4,
  parameter  int ORDER_ADDR_BITS       = 6,
  localparam int ENG_W                 = decompress_pkg::eng_w_of(DECOMPRESS_ENGINES_NO),
  localparam int LEN_W                 = 8 * VALUE_SIZE_BYTES_NO
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [LEN_W-1:0]                 req_len,
  input  logic                             req_valid,
  output logic                             req_ready,
  input  logic [DECOMPRESS_ENGINES_NO-1:0] eng_almost_full,
  output logic [ENG_W-1:0]                 grant_engine,
  output logic [LEN_W-1:0]                 grant_len,
  output logic                             grant_valid,
  input  logic                             grant_ready,
  output logic [ENG_W-1:0]                 ord_engine,
  output logic                             ord_valid,
  input  logic                             ord_ready,
  output logic [ENG_W:0]                   busy_engines
);

  localparam logic [CREDIT_W-1:0] C_MAX_CREDIT = CREDIT_W'(MAX_OUTSTANDING);

  sched_state_t                     r_state;
  sched_state_t                     w_next_state;
  logic [CREDIT_W-1:0]              r_credit [DECOMPRESS_ENGINES_NO];
  logic [ENG_W-1:0]                 r_rr_ptr;
  logic [ENG_W-1:0]                 r_grant_engine;
  logic [LEN_W-1:0]                 r_len;
  logic [ENG_W:0]                   r_busy;
  logic [ENG_W:0]                   w_busy_count;
  logic [DECOMPRESS_ENGINES_NO-1:0] w_elig;
  logic [DECOMPRESS_ENGINES_NO-1:0] w_inc;
  logic [DECOMPRESS_ENGINES_NO-1:0] w_dec;
  logic [DECOMPRESS_ENGINES_NO-1:0] w_busy_vec;
  logic [ENG_W:0]                   w_pick_res;
  logic                             w_found;
  logic [ENG_W-1:0]                 w_pick;
  logic                             w_hs;
  logic                             w_pop;
  logic                             w_fifo_full;
  logic                             w_fifo_empty;
  logic [ORDER_ADDR_BITS:0]         w_unused_fifo_count;

  // Scan the eligibility vector rotated so that bit 0 is the round-robin
  // pointer; returns {found, lane}.
  function automatic logic [ENG_W:0] rr_pick(
    input logic [DECOMPRESS_ENGINES_NO-1:0] elig,
    input logic [ENG_W-1:0]                 ptr
  );
    logic [DECOMPRESS_ENGINES_NO-1:0] rot;
    logic [ENG_W:0]                   res;
    int                               idx;
    res = '0;
    for (int k = 0; k < DECOMPRESS_ENGINES_NO; k++) begin
      idx = int'(ptr) + k;
      if (idx >= DECOMPRESS_ENGINES_NO) idx = idx - DECOMPRESS_ENGINES_NO;
      rot[k] = elig[idx];
    end
    for (int k = DECOMPRESS_ENGINES_NO - 1; k >= 0; k--) begin
      if (rot[k]) begin
        idx = int'(ptr) + k;
        if (idx >= DECOMPRESS_ENGINES_NO) idx = idx - DECOMPRESS_ENGINES_NO;
        res = {1'b1, ENG_W'(idx)};
      end
    end
    return res;
  endfunction

  assign w_hs      = grant_valid && grant_ready;
  assign w_pop     = ord_valid && ord_ready;
  assign ord_valid = !w_fifo_empty;
  assign grant_len = r_len;

  // Per-lane eligibility and credit movement strobes
  for (genvar gi = 0; gi < DECOMPRESS_ENGINES_NO; gi++) begin : g_lane
    assign w_elig[gi]     = (r_credit[gi] != '0) && !eng_almost_full[gi] && !w_fifo_full;
    assign w_dec[gi]      = w_hs && (grant_engine == ENG_W'(gi));
    assign w_inc[gi]      = w_pop && (ord_engine == ENG_W'(gi));
    assign w_busy_vec[gi] = (r_credit[gi] != C_MAX_CREDIT);
  end

  assign w_pick_res = rr_pick(w_elig, r_rr_ptr);
  assign w_found    = w_pick_res[ENG_W];
  assign w_pick     = w_pick_res[ENG_W-1:0];

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next state and handshake outputs; a lane found in SEARCH is offered in
  // the same cycle so a grant can complete every second cycle.
  always_comb begin
    w_next_state = r_state;
    req_ready    = 1'b0;
    grant_valid  = 1'b0;
    grant_engine = r_grant_engine;
    case (r_state)
      ST_IDLE: begin
        req_ready = !rst;
        if (req_valid && req_ready) begin
          w_next_state = ST_SEARCH;
        end
      end
      ST_SEARCH: begin
        if (w_found) begin
          grant_valid  = 1'b1;
          grant_engine = w_pick;
          w_next_state = grant_ready ? ST_IDLE : ST_GRANT;
        end
      end
      ST_GRANT: begin
        grant_valid = 1'b1;
        if (grant_ready) begin
          w_next_state = ST_IDLE;
        end
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  // Request length latch, held grant lane and round-robin pointer
  always_ff @(posedge clk) begin
    if (rst) begin
      r_len          <= '0;
      r_grant_engine <= '0;
      r_rr_ptr       <= '0;
    end else begin
      if (req_valid && req_ready) begin
        r_len <= req_len;
      end
      if ((r_state == ST_SEARCH) && w_found) begin
        r_grant_engine <= w_pick;
      end
      if (w_hs) begin
        r_rr_ptr <= (grant_engine == ENG_W'(DECOMPRESS_ENGINES_NO - 1)) ?
                    '0 : grant_engine + 1'b1;
      end
    end
  end

  // Credits: grant consumes, drain returns; both on one lane cancel out and
  // a return at the limit saturates.
  always_ff @(posedge clk) begin
    for (int i = 0; i < DECOMPRESS_ENGINES_NO; i++) begin
      if (rst) begin
        r_credit[i] <= C_MAX_CREDIT;
      end else if (w_inc[i] && !w_dec[i]) begin
        if (r_credit[i] != C_MAX_CREDIT) begin
          r_credit[i] <= r_credit[i] + 1'b1;
        end
      end else if (w_dec[i] && !w_inc[i]) begin
        r_credit[i] <= r_credit[i] - 1'b1;
      end
    end
  end

  // Count of lanes holding at least one in-flight value
  always_comb begin
    w_busy_count = '0;
    for (int i = 0; i < DECOMPRESS_ENGINES_NO; i++) begin
      w_busy_count = w_busy_count + (ENG_W+1)'(w_busy_vec[i]);
    end
  end

  // Registered busy-lane count
  always_ff @(posedge clk) begin
    if (rst) begin
      r_busy <= '0;
    end else begin
      r_busy <= w_busy_count;
    end
  end

  assign busy_engines = r_busy;

  decompress_order_fifo #(
    .WIDTH     (ENG_W),
    .ADDR_BITS (ORDER_ADDR_BITS)
  ) u_order_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_hs),
    .i_data  (grant_engine),
    .i_pop   (w_pop),
    .o_data  (ord_engine),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty),
    .o_count (w_unused_fifo_count)
  );

endmodule
`default_nettype wire

// File: tb/tb_decompress_dispatch_sched.sv
`default_nettype none
// ============================================================================
// Module      : tb_decompress_dispatch_sched
// Description : Self-checking bench for decompress_dispatch_sched with a
//               queue-based reference model of credits and grant order.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_decompress_dispatch_sched;

  localparam int N     = 24;
  localparam int MAXO  = 4;
  localparam int DEPTH = 64;

  logic        clk;
  logic        rst;
  logic [15:0] req_len;
  logic        req_valid;
  logic        req_ready;
  logic [23:0] eng_almost_full;
  logic [4:0]  grant_engine;
  logic [15:0] grant_len;
  logic        grant_valid;
  logic        grant_ready;
  logic [4:0]  ord_engine;
  logic        ord_valid;
  logic        ord_ready;
  logic [5:0]  busy_engines;

  int vectors;
  int errors;

  // Reference model state
  int m_credit [N];
  int m_q [$];
  int m_ptr;

  decompress_dispatch_sched #(
    .DECOMPRESS_ENGINES_NO (N),
    .VALUE_SIZE_BYTES_NO   (2),
    .MAX_OUTSTANDING       (MAXO),
    .ORDER_ADDR_BITS       (6)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .req_len         (req_len),
    .req_valid       (req_valid),
    .req_ready       (req_ready),
    .eng_almost_full (eng_almost_full),
    .grant_engine    (grant_engine),
    .grant_len       (grant_len),
    .grant_valid     (grant_valid),
    .grant_ready     (grant_ready),
    .ord_engine      (ord_engine),
    .ord_valid       (ord_valid),
    .ord_ready       (ord_ready),
    .busy_engines    (busy_engines)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog expired");
  end

  function automatic void model_reset();
    for (int i = 0; i < N; i++) m_credit[i] = MAXO;
    m_q.delete();
    m_ptr = 0;
  endfunction

  function automatic int model_pick(input logic [23:0] af);
    int l;
    if (m_q.size() >= DEPTH) return -1;
    for (int k = 0; k < N; k++) begin
      l = (m_ptr + k) % N;
      if (m_credit[l] > 0 && af[l] == 1'b0) return l;
    end
    return -1;
  endfunction

  function automatic void model_grant(input int l);
    m_credit[l] = m_credit[l] - 1;
    m_q.push_back(l);
    m_ptr = (l + 1) % N;
  endfunction

  function automatic void model_pop();
    int l;
    l = m_q.pop_front();
    if (m_credit[l] < MAXO) m_credit[l] = m_credit[l] + 1;
  endfunction

  function automatic int model_busy();
    int c;
    c = 0;
    for (int i = 0; i < N; i++) if (m_credit[i] < MAXO) c++;
    return c;
  endfunction

  // All tasks start and end 1 time unit after a rising edge.
  task automatic do_reset();
    rst = 1'b1; req_valid = 1'b0; req_len = '0; grant_ready = 1'b0;
    ord_ready = 1'b0; eng_almost_full = '0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
  endtask

  task automatic check_busy();
    @(posedge clk); #4;
    vectors++;
    if (busy_engines !== 6'(model_busy())) begin
      errors++;
      $display("FAIL busy: got %0d expected %0d", busy_engines, model_busy());
    end
    @(posedge clk); #1;
  endtask

  task automatic do_request(input logic [15:0] len, input logic [23:0] af, input int delay);
    int exp;
    req_valid = 1'b1; req_len = len; eng_almost_full = af; grant_ready = 1'b0;
    #4;
    vectors++;
    if (req_ready !== 1'b1 || grant_valid !== 1'b0) begin
      errors++;
      $display("FAIL accept: req_ready=%b grant_valid=%b expected 1/0", req_ready, grant_valid);
    end
    @(posedge clk); #1;
    req_valid = 1'b0; req_len = 16'($urandom);
    exp = model_pick(af);
    for (int d = 0; d <= delay; d++) begin
      grant_ready = (d == delay);
      if (d > 0) eng_almost_full = '1;
      #4;
      vectors++;
      if (grant_valid !== 1'b1 || grant_engine !== exp[4:0] || grant_len !== len) begin
        errors++;
        $display("FAIL grant: valid=%b engine=%0d len=%h expected valid=1 engine=%0d len=%h",
                 grant_valid, grant_engine, grant_len, exp, len);
      end
      @(posedge clk); #1;
    end
    grant_ready = 1'b0; eng_almost_full = af;
    model_grant(exp);
  endtask

  task automatic pop_one();
    int h;
    h = m_q[0];
    ord_ready = 1'b1;
    #4;
    vectors++;
    if (ord_valid !== 1'b1 || ord_engine !== h[4:0]) begin
      errors++;
      $display("FAIL order: valid=%b engine=%0d expected valid=1 engine=%0d", ord_valid, ord_engine, h);
    end
    @(posedge clk); #1;
    ord_ready = 1'b0;
    model_pop();
  endtask

  task automatic blocked_then_pop(input logic [15:0] len, input logic [23:0] af, input int nwait);
    int exp;
    int h;
    req_valid = 1'b1; req_len = len; eng_almost_full = af; grant_ready = 1'b1;
    #4;
    vectors++;
    if (req_ready !== 1'b1) begin
      errors++;
      $display("FAIL blocked_accept: req_ready=%b expected 1", req_ready);
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
    for (int i = 0; i < nwait; i++) begin
      #4;
      vectors++;
      if (grant_valid !== 1'b0) begin
        errors++;
        $display("FAIL blocked: grant_valid=%b engine=%0d expected 0", grant_valid, grant_engine);
      end
      @(posedge clk); #1;
    end
    h = m_q[0];
    ord_ready = 1'b1;
    #4;
    vectors++;
    if (ord_valid !== 1'b1 || ord_engine !== h[4:0] || grant_valid !== 1'b0) begin
      errors++;
      $display("FAIL blocked_pop: ord_valid=%b ord_engine=%0d grant_valid=%b expected 1/%0d/0",
               ord_valid, ord_engine, grant_valid, h);
    end
    @(posedge clk); #1;
    ord_ready = 1'b0;
    model_pop();
    exp = model_pick(af);
    #4;
    vectors++;
    if (grant_valid !== 1'b1 || grant_engine !== exp[4:0] || grant_len !== len) begin
      errors++;
      $display("FAIL unblock: valid=%b engine=%0d len=%h expected valid=1 engine=%0d len=%h",
               grant_valid, grant_engine, grant_len, exp, len);
    end
    @(posedge clk); #1;
    grant_ready = 1'b0;
    model_grant(exp);
  endtask

  task automatic test_reset();
    rst = 1'b1; req_valid = 1'b0; req_len = '0; grant_ready = 1'b0;
    ord_ready = 1'b0; eng_almost_full = '0;
    @(posedge clk); #4;
    vectors++;
    if (req_ready !== 1'b0 || grant_valid !== 1'b0) begin
      errors++;
      $display("FAIL in_reset: req_ready=%b grant_valid=%b expected 0/0", req_ready, grant_valid);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
    #4;
    vectors++;
    if (req_ready !== 1'b1 || grant_valid !== 1'b0 || grant_engine !== 5'd0 ||
        grant_len !== 16'd0 || ord_valid !== 1'b0 || busy_engines !== 6'd0) begin
      errors++;
      $display("FAIL after_reset: rdy=%b gv=%b ge=%0d gl=%h ov=%b busy=%0d expected 1/0/0/0/0/0",
               req_ready, grant_valid, grant_engine, grant_len, ord_valid, busy_engines);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_single();
    int h;
    do_reset();
    do_request(16'd40, 24'h0, 0);
    h = m_q[0];
    #4;
    vectors++;
    if (ord_valid !== 1'b1 || ord_engine !== h[4:0]) begin
      errors++;
      $display("FAIL single_order: valid=%b engine=%0d expected 1/%0d", ord_valid, ord_engine, h);
    end
    @(posedge clk); #1;
    check_busy();
  endtask

  task automatic test_back_to_back();
    do_reset();
    for (int i = 0; i < 30; i++) do_request(16'($urandom), 24'h0, 0);
    check_busy();
    while (m_q.size() > 0) pop_one();
    #4;
    vectors++;
    if (ord_valid !== 1'b0) begin
      errors++;
      $display("FAIL drained: ord_valid=%b expected 0", ord_valid);
    end
    @(posedge clk); #1;
    check_busy();
  endtask

  task automatic test_skip();
    do_reset();
    do_request(16'h1111, 24'h0, 0);
    do_request(16'h2222, 24'h000006, 0);
    do_request(16'h3333, 24'h000006, 1);
  endtask

  task automatic test_exhausted();
    logic [23:0] af;
    do_reset();
    af = ~(24'h1 << 5);
    for (int i = 0; i < 4; i++) do_request(16'($urandom), af, 0);
    blocked_then_pop(16'h0555, af, 3);
    check_busy();
  endtask

  task automatic test_same_cycle();
    logic [23:0] af;
    int exp;
    int h;
    do_reset();
    af = ~(24'h1 << 7);
    do_request(16'h0707, af, 0);
    req_valid = 1'b1; req_len = 16'h7777; eng_almost_full = af; grant_ready = 1'b0;
    #4;
    vectors++;
    if (req_ready !== 1'b1) begin
      errors++;
      $display("FAIL same_accept: req_ready=%b expected 1", req_ready);
    end
    @(posedge clk); #1;
    req_valid = 1'b0; grant_ready = 1'b1; ord_ready = 1'b1;
    exp = model_pick(af);
    h = m_q[0];
    #4;
    vectors++;
    if (grant_valid !== 1'b1 || grant_engine !== exp[4:0] || ord_valid !== 1'b1 || ord_engine !== h[4:0]) begin
      errors++;
      $display("FAIL same_cycle: gv=%b ge=%0d ov=%b oe=%0d expected 1/%0d/1/%0d",
               grant_valid, grant_engine, ord_valid, ord_engine, exp, h);
    end
    @(posedge clk); #1;
    grant_ready = 1'b0; ord_ready = 1'b0;
    model_pop();
    model_grant(exp);
    h = m_q[0];
    #4;
    vectors++;
    if (ord_valid !== 1'b1 || ord_engine !== h[4:0]) begin
      errors++;
      $display("FAIL same_order: valid=%b engine=%0d expected 1/%0d", ord_valid, ord_engine, h);
    end
    @(posedge clk); #1;
    for (int i = 0; i < 3; i++) do_request(16'($urandom), af, 0);
    blocked_then_pop(16'h0777, af, 2);
  endtask

  task automatic test_fifo_full();
    do_reset();
    for (int i = 0; i < DEPTH; i++) do_request(16'($urandom), 24'h0, 0);
    blocked_then_pop(16'hF0F0, 24'h0, 3);
    pop_one();
    req_valid = 1'b1; req_len = 16'hABCD; eng_almost_full = '0; grant_ready = 1'b0;
    @(posedge clk); #1;
    req_valid = 1'b0;
    #4;
    vectors++;
    if (grant_valid !== 1'b1) begin
      errors++;
      $display("FAIL pre_reset_grant: grant_valid=%b expected 1", grant_valid);
    end
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
    #4;
    vectors++;
    if (grant_valid !== 1'b0 || ord_valid !== 1'b0 || req_ready !== 1'b1) begin
      errors++;
      $display("FAIL mid_reset: gv=%b ov=%b rdy=%b expected 0/0/1", grant_valid, ord_valid, req_ready);
    end
    @(posedge clk); #1;
    check_busy();
    do_request(16'h0101, 24'h0, 0);
  endtask

  task automatic test_random();
    logic [23:0] af;
    do_reset();
    for (int it = 0; it < 40; it++) begin
      if (m_q.size() > 0 && ($urandom % 3) == 0) pop_one();
      if (m_q.size() > 0 && ($urandom % 4) == 0) pop_one();
      while (m_q.size() >= DEPTH - 4) pop_one();
      af = 24'($urandom & $urandom);
      if (model_pick(af) < 0) begin
        while (m_q.size() > 0) pop_one();
        if (model_pick(af) < 0) af = '0;
      end
      do_request(16'($urandom), af, int'($urandom_range(0, 2)));
      if ((it % 8) == 7) check_busy();
    end
  endtask

  initial begin
    vectors = 0;
    errors  = 0;
    test_reset();
    test_single();
    test_back_to_back();
    test_skip();
    test_exhausted();
    test_same_cycle();
    test_fifo_full();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
`default_nettype wire
